// File: rtl/step_sequencer.sv
// Purpose: frame-rate game controller that strobes the ball/paddle engine and sequences
//          reset, serve freeze, play, pause and game-over.
// Latency: every output is a register; a button pulse acts on the edge that samples it.
//          The step strobe is high on the cycle after the tick. No backpressure: the
//          engine must finish each update within STEP_PERIOD cycles.
//
// Ports:
//   clk        system clock
//   rst_n      synchronous reset, ACTIVE-HIGH (the name is kept for compatibility)
//   start_btn  one-cycle pulse: start a game, or restart from PAUSE/OVER
//   pause_btn  one-cycle pulse: toggle between PLAY and PAUSE
//   ai_enable  level: 1 = left paddles driven by AI
//   l_score    left score reported by the engine (9-bit unsigned)
//   r_score    right score reported by the engine (9-bit unsigned)
//   stclk      one-cycle step strobe to the engine
//   eng_rst    active-high synchronous reset to the engine
//   aim        AI select to the engine, only changed away from strobes
//   state      FSM state code (IDLE=0 ENG_RST=1 SERVE=2 PLAY=3 PAUSE=4 OVER=5)
//   winner     0 none, 1 left, 2 right, 3 both
//   frame_cnt  steps issued in the current game, wraps at 16 bits

module step_sequencer #(
  parameter int STEP_PERIOD = 1666667, // clk cycles per frame tick, must be >= 8
  parameter int SERVE_STEPS = 60,      // frame ticks of freeze before play resumes
  parameter int WIN_SCORE   = 11       // score that ends the game
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_btn,
  input  logic        pause_btn,
  input  logic        ai_enable,
  input  logic [8:0]  l_score,
  input  logic [8:0]  r_score,
  output logic        stclk,
  output logic        eng_rst,
  output logic        aim,
  output logic [2:0]  state,
  output logic [1:0]  winner,
  output logic [15:0] frame_cnt
);

  localparam int TW = (STEP_PERIOD > 1) ? $clog2(STEP_PERIOD) : 1;
  localparam int SW = (SERVE_STEPS > 1) ? $clog2(SERVE_STEPS) : 1;

  localparam logic [TW-1:0] TICK_LAST  = TW'(STEP_PERIOD - 1);
  localparam logic [SW-1:0] SERVE_LAST = SW'(SERVE_STEPS - 1);
  localparam logic [8:0]    WIN        = 9'(WIN_SCORE);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ENG_RST = 3'd1,
    S_SERVE   = 3'd2,
    S_PLAY    = 3'd3,
    S_PAUSE   = 3'd4,
    S_OVER    = 3'd5
  } state_t;

  state_t         st;
  logic [TW-1:0]  tick_cnt;
  logic [SW-1:0]  serve_cnt;
  logic           rst_phase;   // 0 on the first engine-reset cycle, 1 on the second
  logic [8:0]     prev_l;
  logic [8:0]     prev_r;

  logic tick;
  logic stclk_nxt;
  logic score_chg;
  logic l_win;
  logic r_win;
  logic restart;

  always_comb begin
    tick      = (tick_cnt == TICK_LAST);
    // The strobe follows the tick by one cycle and is owned purely by PLAY, so
    // a tick on the cycle PLAY is left still produces its step.
    stclk_nxt = (st == S_PLAY) && tick;
    score_chg = (l_score != prev_l) || (r_score != prev_r);
    l_win     = (l_score >= WIN);
    r_win     = (r_score >= WIN);
    // start is only honoured where play is not running; it beats pause_btn.
    restart   = start_btn && ((st == S_IDLE) || (st == S_PAUSE) || (st == S_OVER));
  end

  assign state = st;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      st        <= S_IDLE;
      tick_cnt  <= '0;
      serve_cnt <= '0;
      rst_phase <= 1'b0;
      prev_l    <= '0;
      prev_r    <= '0;
      stclk     <= 1'b0;
      eng_rst   <= 1'b1;
      aim       <= 1'b0;
      winner    <= 2'd0;
      frame_cnt <= '0;
    end else begin
      // Free-running frame timer; entering SERVE overrides this below so the
      // freeze always lasts a whole number of frames.
      tick_cnt <= tick ? '0 : tick_cnt + TW'(1);

      stclk <= stclk_nxt;
      if (stclk_nxt) begin
        frame_cnt <= frame_cnt + 16'd1;
      end

      // Only move aim when neither the current nor the next cycle carries a
      // strobe, so the engine never samples it mid-change.
      if (!stclk && !stclk_nxt) begin
        aim <= ai_enable;
      end

      if (restart) begin
        st        <= S_ENG_RST;
        rst_phase <= 1'b0;
        eng_rst   <= 1'b1;
        frame_cnt <= '0;
        winner    <= 2'd0;
        prev_l    <= '0;
        prev_r    <= '0;
      end else begin
        case (st)
          S_IDLE: begin
            eng_rst <= 1'b1;
          end

          S_ENG_RST: begin
            if (!rst_phase) begin
              rst_phase <= 1'b1;
            end else begin
              st        <= S_SERVE;
              eng_rst   <= 1'b0;
              tick_cnt  <= '0;
              serve_cnt <= '0;
            end
          end

          S_SERVE: begin
            if (tick) begin
              if (serve_cnt == SERVE_LAST) begin
                serve_cnt <= '0;
                st        <= S_PLAY;
              end else begin
                serve_cnt <= serve_cnt + SW'(1);
              end
            end
          end

          S_PLAY: begin
            // A point ends the rally before a pause request is considered.
            if (score_chg) begin
              prev_l <= l_score;
              prev_r <= r_score;
              if (l_win || r_win) begin
                winner <= {r_win, l_win};
                st     <= S_OVER;
              end else begin
                st        <= S_SERVE;
                tick_cnt  <= '0;
                serve_cnt <= '0;
              end
            end else if (pause_btn) begin
              st <= S_PAUSE;
            end
          end

          S_PAUSE: begin
            if (pause_btn) begin
              st <= S_PLAY;
            end
          end

          S_OVER: begin
            // Engine left out of reset so it keeps showing the final frame.
          end

          default: begin
            st      <= S_IDLE;
            eng_rst <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_step_sequencer.sv
module tb_step_sequencer;

  localparam int P = 10;
  localparam int S = 3;
  localparam int W = 3;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start_btn;
  logic        pause_btn;
  logic        ai_enable;
  logic [8:0]  l_score;
  logic [8:0]  r_score;
  logic        stclk;
  logic        eng_rst;
  logic        aim;
  logic [2:0]  state;
  logic [1:0]  winner;
  logic [15:0] frame_cnt;

  step_sequencer #(
    .STEP_PERIOD(P),
    .SERVE_STEPS(S),
    .WIN_SCORE  (W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_btn(start_btn),
    .pause_btn(pause_btn),
    .ai_enable(ai_enable),
    .l_score  (l_score),
    .r_score  (r_score),
    .stclk    (stclk),
    .eng_rst  (eng_rst),
    .aim      (aim),
    .state    (state),
    .winner   (winner),
    .frame_cnt(frame_cnt)
  );

  typedef struct packed {
    logic [2:0]  st;
    logic        stclk;
    logic        eng;
    logic        aim;
    logic [1:0]  win;
    logic [15:0] fc;
  } obs_t;

  typedef struct {
    int   cyc;
    obs_t o;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;

  // Reference model: game phase plus timestamps; tick timing comes from the
  // distance to the last time the frame timer restarted.
  int          m_st;
  int          m_org;     // edge at which the frame timer last restarted
  int          m_rst_at;  // edge at which engine reset began
  bit          m_stclk;
  bit          m_eng;
  bit          m_aim;
  logic [1:0]  m_win;
  logic [15:0] m_frames;
  logic [8:0]  m_pl;
  logic [8:0]  m_pr;

  int          next_e;
  bit          cur_ai;
  logic [8:0]  cur_l;
  logic [8:0]  cur_r;

  task automatic enter_eng_rst(input int e);
    m_st     = 1;
    m_rst_at = e;
    m_eng    = 1;
    m_frames = 0;
    m_win    = 0;
    m_pl     = 0;
    m_pr     = 0;
  endtask

  // Outputs expected right after edge e, given the inputs currently driven.
  task automatic model_edge(input int e);
    bit tick;
    bit nst;
    bit lw;
    bit rw;
    if (rst_n) begin
      m_st = 0; m_org = e; m_stclk = 0; m_eng = 1; m_aim = 0;
      m_win = 0; m_frames = 0; m_pl = 0; m_pr = 0;
      return;
    end
    tick = (((e - 1 - m_org) % P) == P - 1);
    nst  = (m_st == 3) && tick;
    if (nst) m_frames = m_frames + 16'd1;
    if (!m_stclk && !nst) m_aim = ai_enable;
    m_stclk = nst;
    lw = (l_score >= W);
    rw = (r_score >= W);
    case (m_st)
      0: if (start_btn) enter_eng_rst(e);
      1: if (e - m_rst_at == 2) begin m_st = 2; m_eng = 0; m_org = e; end
      2: if (e - m_org == S * P) m_st = 3;
      3: begin
        if (l_score != m_pl || r_score != m_pr) begin
          m_pl = l_score;
          m_pr = r_score;
          if (lw || rw) begin m_win = {rw, lw}; m_st = 5; end
          else begin m_st = 2; m_org = e; end
        end else if (pause_btn) begin
          m_st = 4;
        end
      end
      4: if (start_btn) enter_eng_rst(e); else if (pause_btn) m_st = 3;
      5: if (start_btn) enter_eng_rst(e);
      default: m_st = 0;
    endcase
  endtask

  // Drive one edge's inputs, push its expected outputs, then let the edge happen.
  task automatic cyc(input bit s = 0, input bit p = 0, input bit r = 0);
    exp_t it;
    rst_n     = r;
    start_btn = s;
    pause_btn = p;
    if ($urandom_range(0, 3) == 0) cur_ai = ~cur_ai;
    ai_enable = cur_ai;
    l_score   = cur_l;
    r_score   = cur_r;
    model_edge(next_e);
    it.cyc     = next_e;
    it.o.st    = 3'(m_st);
    it.o.stclk = m_stclk;
    it.o.eng   = m_eng;
    it.o.aim   = m_aim;
    it.o.win   = m_win;
    it.o.fc    = m_frames;
    q.push_back(it);
    next_e++;
    @(posedge clk);
    #1;
  endtask

  task automatic run_until(input int s, input int lim);
    int n;
    n = 0;
    while (state != 3'(s) && n < lim) begin
      cyc();
      n++;
    end
    tests++;
    if (state != 3'(s)) begin
      fails++;
      $display("FAIL reach_state got=%0d want=%0d after %0d cycles", state, s, n);
    end
  endtask

  // Monitor: each cycle, pop the entry for this edge and compare.
  initial begin : monitor
    int   mcyc;
    bit   prev_stclk;
    exp_t x;
    obs_t a;
    mcyc = 0;
    prev_stclk = 0;
    forever begin
      @(posedge clk);
      mcyc++;
      #2;
      while (q.size() > 0 && q[0].cyc < mcyc) begin
        x = q.pop_front();
        tests++;
        fails++;
        $display("FAIL stale_expect cyc=%0d now=%0d", x.cyc, mcyc);
      end
      if (q.size() > 0 && q[0].cyc == mcyc) begin
        x = q.pop_front();
        a = {state, stclk, eng_rst, aim, winner, frame_cnt};
        tests++;
        if (a !== x.o) begin
          fails++;
          $display("FAIL outputs cyc=%0d got st=%0d stclk=%b eng_rst=%b aim=%b win=%0d fc=%0d want st=%0d stclk=%b eng_rst=%b aim=%b win=%0d fc=%0d",
                   mcyc, state, stclk, eng_rst, aim, winner, frame_cnt,
                   x.o.st, x.o.stclk, x.o.eng, x.o.aim, x.o.win, x.o.fc);
        end
      end
      if (stclk === 1'b1) begin
        tests++;
        if (prev_stclk) begin
          fails++;
          $display("FAIL stclk_width cyc=%0d got two consecutive high cycles want one", mcyc);
        end
      end
      prev_stclk = (stclk === 1'b1);
    end
  end

  initial begin : stim
    bit s;
    bit p;
    bit r;
    next_e = 1;
    cur_ai = 0;
    cur_l  = 0;
    cur_r  = 0;

    // Reset, then idle.
    cyc(0, 0, 1);
    cyc(0, 0, 1);
    repeat (20) cyc();

    // Start: engine reset, serve freeze, play with steady strobes.
    cyc(1);
    run_until(3, 60);
    repeat (55) cyc();

    // Point scored without a win: back to serve, frame count kept.
    cur_l = 1;
    cyc();
    repeat (50) cyc();
    run_until(3, 60);

    // Right reaches the target: game over, then restart.
    cur_r = 3;
    cyc();
    repeat (20) cyc();
    cur_l = 0; cur_r = 0;
    cyc(1);
    run_until(3, 60);
    repeat (7) cyc();

    // Both reach the target on the same cycle.
    cur_l = 3; cur_r = 3;
    cyc();
    repeat (5) cyc();

    // Pause / resume, then pause coinciding with a point.
    cur_l = 0; cur_r = 0;
    cyc(1);
    run_until(3, 60);
    repeat (13) cyc();
    cyc(0, 1);
    repeat (50) cyc();
    cyc(0, 1);
    repeat (15) cyc();
    cur_l = 1;
    cyc(0, 1);
    repeat (40) cyc();

    // Start and pause together while paused: restart wins.
    run_until(3, 60);
    cyc(0, 1);
    repeat (5) cyc();
    cur_l = 0; cur_r = 0;
    cyc(1, 1);
    run_until(3, 60);

    // Randomized play.
    repeat (1500) begin
      s = ($urandom_range(0, 149) == 0);
      p = ($urandom_range(0, 29) == 0);
      r = ($urandom_range(0, 599) == 0);
      if ($urandom_range(0, 49) == 0) begin
        if ($urandom_range(0, 1) == 1) cur_l = cur_l + 9'd1;
        else cur_r = cur_r + 9'd1;
      end
      if (s) begin cur_l = 0; cur_r = 0; end
      cyc(s, p, r);
    end

    // Reset in the middle of play.
    cur_l = 0; cur_r = 0;
    cyc(1);
    run_until(3, 200);
    repeat (12) cyc();
    cyc(0, 0, 1);
    repeat (5) cyc();

    repeat (3) @(posedge clk);
    #3;
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain got=%0d pending want=0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/step_sequencer.md
Name: step_sequencer

Overview:
- Top-level game controller for the ball/paddle physics engine.
- Generates the engine's step strobe (stclk) at a fixed frame rate.
- Holds the engine in reset between games, freezes play for a serve delay after every point, and handles pause/resume.
- Ends the game when a score reaches the target, and registers the AI/player paddle-control select so it changes only between steps.

Parameters:
- STEP_PERIOD, 1666667, clk cycles per frame tick (100 MHz / 60 Hz); must be >= 8 so the engine's 5-ball update sweep completes between strobes.
- SERVE_STEPS, 60, frame ticks of freeze after game start or after a point.
- WIN_SCORE, 11, score (9-bit, unsigned) that ends the game.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous reset, active-high despite the name
- start_btn  in  1  one-cycle pulse, debounced upstream; starts or restarts a game
- pause_btn  in  1  one-cycle pulse; toggles pause
- ai_enable  in  1  level; 1 = left paddles driven by AI
- l_score  in  9  left score from physics engine
- r_score  in  9  right score from physics engine
- stclk  out  1  one-cycle step strobe to engine
- eng_rst  out  1  active-high synchronous reset to engine
- aim  out  1  registered AI select to engine
- state  out  3  current FSM state code
- winner  out  2  0 none, 1 left, 2 right, 3 both
- frame_cnt  out  16  steps issued in current game

Behaviour:
- All outputs are registered.
- Reset values: state=IDLE, stclk=0, eng_rst=1, aim=0, winner=0, frame_cnt=0, tick_cnt=0, serve_cnt=0, prev scores=0.
- Tick counter:
  - tick_cnt counts 0..STEP_PERIOD-1 and wraps.
  - tick is true on the cycle tick_cnt==STEP_PERIOD-1.
  - Free-running in every state except that it is cleared to 0 on entry to SERVE.
- State codes: IDLE=0, ENG_RST=1, SERVE=2, PLAY=3, PAUSE=4, OVER=5.
- IDLE:
  - eng_rst=1.
  - start_btn -> ENG_RST.
- ENG_RST:
  - eng_rst=1 for exactly 2 cycles; frame_cnt:=0, winner:=0, prev scores:=0.
  - Then -> SERVE, with eng_rst=0 from the first SERVE cycle.
- SERVE:
  - No stclk.
  - serve_cnt increments per tick; after SERVE_STEPS ticks -> PLAY, serve_cnt:=0.
  - pause_btn and start_btn are ignored.
- PLAY:
  - On each tick, stclk=1 for the following single cycle and frame_cnt increments (wraps 65535->0).
  - Score check every cycle: if l_score!=prev_l or r_score!=prev_r, update prev_l/prev_r to the new values.
    - If either score >= WIN_SCORE: winner := {r_score>=WIN_SCORE, l_score>=WIN_SCORE}, -> OVER.
    - Otherwise -> SERVE.
  - Score check has priority over pause_btn.
  - pause_btn (no score change) -> PAUSE.
  - A tick coinciding with the state-leaving cycle still issues its stclk.
- PAUSE:
  - No stclk; tick_cnt keeps running.
  - pause_btn -> PLAY.
  - start_btn -> ENG_RST (restart).
- OVER:
  - No stclk; eng_rst=0, so the engine keeps displaying its final state.
  - winner is held.
  - start_btn -> ENG_RST.
- aim:
  - aim := ai_enable on any cycle where stclk==0 and the next-cycle stclk will be 0.
  - Therefore aim never changes on the cycle stclk is high nor on the edge that raises it: stable for the engine's sample.
  - In IDLE, aim simply tracks ai_enable one cycle late.
- Simultaneous start_btn and pause_btn: start wins in PAUSE/OVER/IDLE, pause is ignored elsewhere per above.
- Synchronous reset mid-game returns to IDLE on the next edge and asserts eng_rst immediately on that edge.
- stclk pulses are spaced exactly STEP_PERIOD cycles apart while in PLAY; never two consecutive cycles high.

Test Plan:
All scenarios use STEP_PERIOD=10, SERVE_STEPS=3, WIN_SCORE=3.
- Reset, idle 20 cycles -> state=0, eng_rst=1, stclk never high; start_btn -> eng_rst high for exactly 2 more cycles, state 1 then 2.
- After start -> exactly 3 ticks (30 cycles) in SERVE with no stclk, then state=3; stclk pulses every 10 cycles, one cycle wide; frame_cnt=5 after 5 pulses.
- In PLAY, bump l_score 0->1 -> next cycle state=2, stclk stops for 30 cycles, resumes; frame_cnt not cleared; winner=0.
- Raise r_score to 3 -> state=5, winner=2, stclk stops; start_btn -> state=1, winner=0, frame_cnt=0; l_score=3 and r_score=3 on the same cycle -> winner=3.
- pause_btn in PLAY -> state=4, no stclk for 50 cycles; pause_btn again -> state=3, next stclk within 10 cycles; same-cycle pause_btn plus score change -> state=2.
- Toggle ai_enable on the cycle before and during a stclk pulse -> aim constant through the pulse, updates on the first cycle after; assert rst_n mid-PLAY -> state=0, eng_rst=1 the next cycle.
